// File: rtl/dem_dither_quantizer_if.sv
// dem_dither_quantizer_if: sample-in / level-out handshakes plus clip counter for the dithered quantizer
interface dem_dither_quantizer_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 3
);
    logic [INPUT_WIDTH-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [OUTPUT_WIDTH-1:0] out_level;
    logic                    out_clip;
    logic                    out_valid;
    logic                    out_ready;
    logic                    clip_clr;
    logic [15:0]             clip_count;
    modport master (
        output in_data, in_valid, out_ready, clip_clr,
        input  in_ready, out_level, out_clip, out_valid, clip_count
    );
    modport slave (
        input  in_data, in_valid, out_ready, clip_clr,
        output in_ready, out_level, out_clip, out_valid, clip_count
    );
endinterface

// File: rtl/dem_dither_quantizer.sv
// dem_dither_quantizer: two-stage dithered quantizer feeding the DEM switching block; dither enabled by QUANT_DITHER_EN
module dem_dither_quantizer #(
    parameter int         INPUT_WIDTH  = 16,
    parameter int         OUTPUT_WIDTH = 3,
    parameter logic [7:0] LFSR_INIT    = 8'hFF
) (
    input logic                   clk,
    input logic                   rst_n,
    dem_dither_quantizer_if.slave bus
);
    localparam int DW = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam logic [OUTPUT_WIDTH-1:0] MAX_LEVEL = '1;
    logic                    en;
    logic                    take;
    logic                    s1_valid;
    logic [INPUT_WIDTH:0]    s1_sum;
    logic [DW-1:0]           dither;
    logic [OUTPUT_WIDTH:0]   q;
    logic                    clip;
    logic [OUTPUT_WIDTH-1:0] level;
    assign en           = !bus.out_valid || bus.out_ready;
    assign take         = bus.in_valid && en;
    assign bus.in_ready = en;
`ifdef QUANT_DITHER_EN
    logic [7:0] lfsr;
    // LFSR steps only on an accepted sample so idle cycles leave the dither sequence untouched
    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= LFSR_INIT;
        else if (take) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5]};
    end
    assign dither = {lfsr, {(DW-8){1'b0}}};
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_INIT;
    assign dither      = '0;
`endif
    // Stage 1: full-width sum keeps the carry so overflow past full scale is visible as clipping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            if (take) s1_sum <= {1'b0, bus.in_data} + {{(OUTPUT_WIDTH+1){1'b0}}, dither};
        end
    end
    // Truncate to the level field and saturate anything above the top level
    always_comb begin
        q     = s1_sum[INPUT_WIDTH -: OUTPUT_WIDTH+1];
        clip  = q > {1'b0, MAX_LEVEL};
        level = clip ? MAX_LEVEL : q[OUTPUT_WIDTH-1:0];
    end
    // Stage 2: registered output, held while the switching block stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_level <= '0;
            bus.out_clip  <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s1_valid;
            bus.out_level <= level;
            bus.out_clip  <= clip;
        end
    end
    // Saturating count of delivered clipped levels; clear beats a simultaneous increment
    always_ff @(posedge clk) begin
        if (!rst_n) bus.clip_count <= '0;
        else if (bus.clip_clr) bus.clip_count <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_clip && bus.clip_count != 16'hFFFF)
            bus.clip_count <= bus.clip_count + 16'd1;
    end
endmodule

// File: tb/tb_dem_dither_quantizer.sv
// tb_dem_dither_quantizer: directed scoreboard bench for the dithered quantizer (both QUANT_DITHER_EN builds)
module tb_dem_dither_quantizer;
`ifdef QUANT_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif
    localparam int NSAT = DITH ? 65534 : 4;
    typedef struct packed {
        logic [2:0] lvl;
        logic       clip;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    dem_dither_quantizer_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(3)) bus();
    dem_dither_quantizer #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(3), .LFSR_INIT(8'hFF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: every output handshake is matched against the oldest expected level
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got level %0d, expected no output", bus.out_level);
            end else begin
                e = exp_q.pop_front();
                check("out_level", {29'd0, bus.out_level}, {29'd0, e.lvl});
                check("out_clip", {31'd0, bus.out_clip}, {31'd0, e.clip});
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [2:0] lvl, input logic clp);
        int t = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(exp_t'{lvl: lvl, clip: clp});
        end
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.clip_clr = 1'b0;
        exp_q.delete();
        sync();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clip_clr  = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", {31'd0, bus.out_valid}, 0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 1);
        check("reset_out_level", {29'd0, bus.out_level}, 0);
        check("reset_out_clip", {31'd0, bus.out_clip}, 0);
        check("reset_clip_count", {16'd0, bus.clip_count}, 0);
        sync();
        // Back-to-back zero and full-scale samples
        bus.out_ready = 1'b1;
        send(16'h0000, 3'd0, 1'b0);
        send(16'hFFFF, 3'd7, DITH);
        drain();
        check("clip_count_first", {16'd0, bus.clip_count}, {31'd0, DITH});
        sync();
        // Latency through both stages
        do_reset();
        send(16'h2000, 3'd1, 1'b0);
        @(negedge clk);
        check("latency_stage1", {31'd0, bus.out_valid}, 0);
        @(negedge clk);
        check("latency_stage2", {31'd0, bus.out_valid}, 1);
        sync();
        // Level boundaries
        send(16'h2000, 3'd1, 1'b0);
        send(16'hDFFF, DITH ? 3'd7 : 3'd6, 1'b0);
        send(16'hE000, 3'd7, 1'b0);
        send(16'hFFFF, 3'd7, DITH);
        drain();
        sync();
        // Backpressure: stall output for 3 cycles while streaming 4 samples
        do_reset();
        bus.out_ready = 1'b0;
        fork
            begin
                send(16'h4000, 3'd2, 1'b0);
                send(16'h0000, 3'd0, 1'b0);
                send(16'h8000, 3'd4, 1'b0);
                send(16'hC000, 3'd6, 1'b0);
            end
            begin
                t = 0;
                while (!bus.out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_out_valid_seen", {31'd0, bus.out_valid}, 1);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, bus.in_ready}, 0);
                    check("stall_out_valid", {31'd0, bus.out_valid}, 1);
                    check("stall_out_level", {29'd0, bus.out_level}, 2);
                    check("stall_out_clip", {31'd0, bus.out_clip}, 0);
                end
                sync();
                bus.out_ready = 1'b1;
            end
        join
        drain();
        sync();
        // Dither probes: exactly four LFSR steps taken (0xF0 then 0xE0)
        send(16'd480, 3'd0, 1'b0);
        send(16'd1024, DITH ? 3'd1 : 3'd0, 1'b0);
        drain();
        sync();
        // Clip counter saturation
        do_reset();
        bus.out_ready = 1'b1;
        repeat (NSAT) send(16'hFFFF, 3'd7, DITH);
        drain();
        check("clip_count_preload", {16'd0, bus.clip_count}, DITH ? 32'hFFFE : 32'h0);
        sync();
        send(16'hFFFF, 3'd7, DITH);
        send(16'hFFFF, 3'd7, DITH);
        drain();
        check("clip_count_saturate", {16'd0, bus.clip_count}, DITH ? 32'hFFFF : 32'h0);
        sync();
        // Clear coincident with a clipped handshake
        bus.out_ready = 1'b0;
        send(16'hFFFF, 3'd7, DITH);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("clr_out_valid_seen", {31'd0, bus.out_valid}, 1);
        sync();
        bus.clip_clr  = 1'b1;
        bus.out_ready = 1'b1;
        sync();
        bus.clip_clr = 1'b0;
        @(negedge clk);
        check("clip_count_clear", {16'd0, bus.clip_count}, 0);
        sync();
        // Reset with both stages full
        send(16'hFFFF, 3'd7, DITH);
        drain();
        check("clip_count_prereset", {16'd0, bus.clip_count}, {31'd0, DITH});
        sync();
        bus.out_ready = 1'b0;
        send(16'h2000, 3'd1, 1'b0);
        send(16'h4000, 3'd2, 1'b0);
        exp_q.delete();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", {31'd0, bus.out_valid}, 0);
        check("midreset_clip_count", {16'd0, bus.clip_count}, 0);
        check("midreset_in_ready", {31'd0, bus.in_ready}, 1);
        sync();
        bus.out_ready = 1'b1;
        send(16'h0000, 3'd0, 1'b0);
        send(16'h0040, DITH ? 3'd1 : 3'd0, 1'b0);
        drain();
        sync();
        // LFSR holds while idle, even with in_data wiggling
        do_reset();
        repeat (10) begin
            bus.in_data = 16'($urandom);
            sync();
        end
        send(16'h0020, DITH ? 3'd1 : 3'd0, 1'b0);
        send(16'h0000, 3'd0, 1'b0);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
